// File: rtl/pdecoder_seq_pkg.sv
// Shared types and width helpers for the sequential one-hot decoder.
package pdecoder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Width of a down-counter that must hold values 0..n; never zero bits wide.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Width of a pointer addressing n entries; never zero bits wide.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdecoder_seq_fifo.sv
// Small synchronous FIFO holding encoded {en, idx} words for the decoder.
// full/empty come from the registered count only, so a pop in the same
// cycle never makes a full FIFO look ready.
module pdecoder_seq_fifo
  import pdecoder_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // Storage: data is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pdecoder_seq.sv
// Sequential 2^IDX_W-line decoder: queued {en, idx} words become timed
// one-hot strobes held for HOLD cycles, each followed by GAP idle cycles.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | nothing driven; pop the next word as soon as one is queued
//  ST_DRIVE | y/y_valid driven; hold_cnt counts down to the end of slot
//  ST_GAP   | y=0, y_valid=0; gap_cnt counts down the idle spacing
module pdecoder_seq
  import pdecoder_seq_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_en,
  output logic [(1<<IDX_W)-1:0]   y,
  output logic                    y_valid,
  output logic                    busy
);

  localparam int N_OUT = 1 << IDX_W;
  localparam int HW    = cnt_w(HOLD);
  localparam int GW    = cnt_w(GAP);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP - 1);

  state_t             state, state_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [GW-1:0]      gap_cnt, gap_n;
  logic [N_OUT-1:0]   y_n;
  logic               y_valid_n;
  logic               push, pop, load;
  logic               empty, full;
  logic               head_en;
  logic [IDX_W-1:0]   head_idx;
  logic [N_OUT-1:0]   y_load;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE) || !empty;
  assign y_load   = head_en ? (N_OUT'(1) << head_idx) : '0;

  pdecoder_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_en, in_idx}),
    .rd_data ({head_en, head_idx}),
    .empty   (empty),
    .full    (full)
  );

  // State, counters and the registered one-hot output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      y        <= y_n;
      y_valid  <= y_valid_n;
    end
  end

  // Next-state logic; 'load' pops the head word and starts a new DRIVE slot.
  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    gap_n     = gap_cnt;
    y_n       = y;
    y_valid_n = y_valid;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) load = 1'b1;
      end
      ST_DRIVE: begin
        if (hold_cnt != '0) begin
          hold_n = hold_cnt - HW'(1);
        end else if (GAP > 0) begin
          y_n       = '0;
          y_valid_n = 1'b0;
          gap_n     = GAP_RELOAD;
          state_n   = ST_GAP;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          y_n       = '0;
          y_valid_n = 1'b0;
          state_n   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt != '0) gap_n = gap_cnt - GW'(1);
        else if (!empty)   load = 1'b1;
        else               state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (load) begin
      pop       = 1'b1;
      y_n       = y_load;
      y_valid_n = 1'b1;
      hold_n    = HOLD_RELOAD;
      state_n   = ST_DRIVE;
    end
  end

endmodule

// File: tb/tb_pdecoder_seq.sv
// Bench for pdecoder_seq: dut_a uses HOLD=4 GAP=1 DEPTH=2, dut_b uses GAP=0.
module tb_pdecoder_seq;

  localparam int HOLD = 4;

  typedef struct {
    logic       en;
    logic [1:0] idx;
    logic [3:0] exp_y;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_a = 1'b0, in_en_a = 1'b0;
  logic [1:0] in_idx_a = '0;
  logic       in_ready_a, y_valid_a, busy_a;
  logic [3:0] y_a;
  logic       in_valid_b = 1'b0, in_en_b = 1'b0;
  logic [1:0] in_idx_b = '0;
  logic       in_ready_b, y_valid_b, busy_b;
  logic [3:0] y_b;

  int total = 0;
  int bad   = 0;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  int   run   [2] = '{0, 0};
  bit   ended [2] = '{0, 0};
  logic [3:0] cur [2];
  bit   saw_full = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  pdecoder_seq #(.IDX_W(2), .HOLD(4), .GAP(1), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_idx(in_idx_a), .in_en(in_en_a), .y(y_a), .y_valid(y_valid_a), .busy(busy_a)
  );

  pdecoder_seq #(.IDX_W(2), .HOLD(4), .GAP(0), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_idx(in_idx_b), .in_en(in_en_b), .y(y_b), .y_valid(y_valid_b), .busy(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every y_valid run must be exactly HOLD cycles of the
  // next expected word; idle cycles must show y=0; dut_a must show a gap.
  task automatic mon(input int w, input logic vld, input logic [3:0] yy);
    if (!rst_n) begin
      run[w]   = 0;
      ended[w] = 0;
      return;
    end
    if (vld) begin
      if (run[w] == 0) begin
        if (w == 0) chk("gap before word a", 32'(ended[w]), 0);
        if ((w == 0 ? q_a.size() : q_b.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL mon%0d unexpected word: got y=%b want none", w, yy);
          cur[w] = yy;
        end else begin
          cur[w] = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        end
      end
      chk($sformatf("mon%0d y", w), 32'(yy), 32'(cur[w]));
      run[w]++;
      ended[w] = (run[w] == HOLD);
      if (ended[w]) run[w] = 0;
    end else begin
      chk($sformatf("mon%0d hold length", w), 32'(run[w]), 0);
      chk($sformatf("mon%0d idle y", w), 32'(yy), 0);
      run[w]   = 0;
      ended[w] = 0;
    end
  endtask

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, y_valid_a, y_a);
    mon(1, y_valid_b, y_b);
  end

  // Offer one word; returns 1 ns after the accepting edge.
  task automatic push(input int w, input logic en, input logic [1:0] idx, input logic [3:0] exp);
    bit done = 0;
    if (w == 0) begin in_valid_a = 1'b1; in_en_a = en; in_idx_a = idx; end
    else        begin in_valid_b = 1'b1; in_en_b = en; in_idx_b = idx; end
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if ((w == 0) ? in_ready_a : in_ready_b) begin
        if (w == 0) q_a.push_back(exp);
        else        q_b.push_back(exp);
        done = 1;
      end else begin
        saw_full = 1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push%0d timeout: got in_ready=0 want 1", w);
    end
    @(posedge clk);
    #1;
    if (w == 0) in_valid_a = 1'b0;
    else        in_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input int w);
    bit idle = 0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      idle = (w == 0) ? !busy_a : !busy_b;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL idle%0d timeout: got busy=1 want 0", w);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset for n edges with in_valid held high, then release.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] one = 4'b0001;
    int seen;

    vecs[0] = '{1'b1, 2'd0, 4'b0001};
    vecs[1] = '{1'b1, 2'd1, 4'b0010};
    vecs[2] = '{1'b1, 2'd2, 4'b0100};
    vecs[3] = '{1'b1, 2'd3, 4'b1000};
    vecs[4] = '{1'b0, 2'd1, 4'b0000};
    vecs[5] = '{1'b1, 2'd3, 4'b1000};
    vecs[6] = '{1'b0, 2'd3, 4'b0000};
    vecs[7] = '{1'b1, 2'd0, 4'b0001};

    // Power-on reset; handshakes offered during reset are ignored.
    do_reset(3);
    @(negedge clk);
    chk("reset y", 32'(y_a), 0);
    chk("reset y_valid", 32'(y_valid_a), 0);
    chk("reset busy", 32'(busy_a), 0);
    chk("reset in_ready", 32'(in_ready_a), 1);
    chk("reset busy b", 32'(busy_b), 0);
    @(posedge clk);
    #1;

    // Single word idx=2 en=1: one cycle latency, HOLD cycles, one gap cycle.
    push(0, 1'b1, 2'd2, 4'b0100);
    @(negedge clk);
    chk("t2 before T1 y_valid", 32'(y_valid_a), 0);
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      chk($sformatf("t2 y cyc%0d", k), 32'(y_a), 32'(4'b0100));
      chk($sformatf("t2 y_valid cyc%0d", k), 32'(y_valid_a), 1);
    end
    @(negedge clk);
    chk("t2 gap y", 32'(y_a), 0);
    chk("t2 gap y_valid", 32'(y_valid_a), 0);
    chk("t2 gap busy", 32'(busy_a), 1);
    @(negedge clk);
    chk("t2 idle busy", 32'(busy_a), 0);
    @(posedge clk);
    #1;

    // en=0 word still takes a full slot with y_valid=1 and y=0.
    push(0, 1'b0, 2'd3, 4'b0000);
    @(negedge clk);
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      chk($sformatf("t3 y cyc%0d", k), 32'(y_a), 0);
      chk($sformatf("t3 y_valid cyc%0d", k), 32'(y_valid_a), 1);
    end
    @(negedge clk);
    chk("t3 gap y_valid", 32'(y_valid_a), 0);
    wait_idle(0);

    // Table burst with in_valid held: FIFO must fill and back-pressure.
    saw_full = 0;
    for (int i = 0; i < 8; i++) push(0, vecs[i].en, vecs[i].idx, vecs[i].exp_y);
    chk("t4 in_ready dropped", 32'(saw_full), 1);
    wait_idle(0);
    chk("t4 words all seen", q_a.size(), 0);

    // Random words scored against a decode of the stimulus.
    for (int i = 0; i < 10; i++) begin
      logic       e = 1'($urandom_range(0, 1));
      logic [1:0] x = 2'($urandom_range(0, 3));
      push(0, e, x, e ? (one << x) : 4'b0000);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    wait_idle(0);
    chk("rand words all seen", q_a.size(), 0);

    // Reset mid-traffic.
    push(0, 1'b1, 2'd1, 4'b0010);
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);
    @(negedge clk);
    chk("t1 y", 32'(y_a), 0);
    chk("t1 y_valid", 32'(y_valid_a), 0);
    chk("t1 busy", 32'(busy_a), 0);
    chk("t1 in_ready", 32'(in_ready_a), 1);
    @(posedge clk);
    #1;

    // Two words queued behind the driven one, reset during DRIVE.
    push(0, 1'b1, 2'd0, 4'b0001);
    push(0, 1'b1, 2'd1, 4'b0010);
    push(0, 1'b1, 2'd2, 4'b0100);
    rst_n = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("t5 y before edge", 32'(y_valid_a), 1);
    @(negedge clk);
    chk("t5 y after edge", 32'(y_a), 0);
    chk("t5 y_valid after edge", 32'(y_valid_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (y_valid_a) seen++;
    end
    chk("t5 stale words", seen, 0);
    chk("t5 busy", 32'(busy_a), 0);
    @(posedge clk);
    #1;

    // GAP=0: back-to-back words with no zero cycle.
    push(1, 1'b1, 2'd0, 4'b0001);
    push(1, 1'b1, 2'd3, 4'b1000);
    for (int k = 0; k < 2 * HOLD; k++) begin
      @(negedge clk);
      chk($sformatf("t6 y cyc%0d", k), 32'(y_b), (k < HOLD) ? 32'(4'b0001) : 32'(4'b1000));
      chk($sformatf("t6 y_valid cyc%0d", k), 32'(y_valid_b), 1);
    end
    @(negedge clk);
    chk("t6 end y", 32'(y_b), 0);
    chk("t6 end y_valid", 32'(y_valid_b), 0);
    wait_idle(1);
    chk("t6 words all seen", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
